// File: rtl/pio_push_seq_pkg.sv
// Shared constants and FSM state type for the push-button event sequencer.
package pio_push_seq_pkg;
    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    localparam logic [1:0] CSR_EVENT  = 2'd0;
    localparam logic [1:0] CSR_STATUS = 2'd1;
    localparam logic [1:0] CSR_MASK   = 2'd2;
    localparam logic [1:0] CSR_TS     = 2'd3;

    localparam int STAT_OVF   = 8;
    localparam int STAT_FULL  = 9;
    localparam int STAT_EMPTY = 10;
    localparam int EVT_VALID  = 31;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_CAP,
        S_PUSH,
        S_MASK
    } state_t;
endpackage

// File: rtl/pio_push_evt_fifo.sv
// Synchronous event FIFO with first-word-fall-through head and level/full/empty flags.
module pio_push_evt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             empty_nxt
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_nxt;
    logic             do_push;
    logic             do_pop;

    assign empty     = (level == '0);
    assign full      = (level == LW'(DEPTH));
    assign do_pop    = pop && !empty;
    // A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head      = mem[rd_ptr];
    assign empty_nxt = (level_nxt == '0);

    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop)
            level_nxt = level + 1'b1;
        else if (do_pop && !do_push)
            level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/pio_push_event_sequencer.sv
// Push-button PIO event sequencer: programs the PIO mask, services its irq and queues
// button events for the CPU. Build macro EVT_TIMESTAMP_EN adds per-event timestamps.
module pio_push_event_sequencer #(
    parameter int              NBTN       = 4,
    parameter int              FIFO_DEPTH = 8,
    parameter logic [NBTN-1:0] INIT_MASK  = NBTN'(4'hF),
    parameter int              TS_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata,
    input  logic        pio_irq,
    input  logic [1:0]  csr_address,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        irq
);
    import pio_push_seq_pkg::*;

    // state  | meaning
    // S_INIT | program mask_reg into PIO irq_mask after reset
    // S_IDLE | wait for a pending mask update or a PIO irq
    // S_RD   | read PIO edge_capture
    // S_CAP  | capture read data, write edge_capture to clear it
    // S_PUSH | queue the captured event if non-zero
    // S_MASK | write updated mask_reg to PIO irq_mask

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef EVT_TIMESTAMP_EN
    localparam int FW = TS_WIDTH + NBTN;
`else
    localparam int FW = NBTN;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [NBTN-1:0] evt;
    logic [NBTN-1:0] mask_reg;
    logic [NBTN-1:0] mask_d;
    logic            mask_pend;
    logic            overflow;
    logic            csr_mask_wr;
    logic            csr_ovf_clr;
    logic            ovf_set;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_empty_nxt;
    logic [LW-1:0]   fifo_level;
    logic [FW-1:0]   fifo_din;
    logic [FW-1:0]   fifo_head;
    logic [NBTN-1:0] head_evt;
    logic            cs_d;
    logic            wn_d;
    logic [1:0]      addr_d;
    logic [31:0]     wd_d;
    logic [31:0]     rd_d;
    logic            unused_in;

    assign unused_in   = ^{pio_readdata, csr_writedata};
    assign csr_mask_wr = csr_write && (csr_address == CSR_MASK);
    assign csr_ovf_clr = csr_write && (csr_address == CSR_STATUS) && csr_writedata[STAT_OVF];
    // Bus write data follows a same-cycle CSR mask write so the newest value goes out.
    assign mask_d      = csr_mask_wr ? csr_writedata[NBTN-1:0] : mask_reg;
    assign fifo_push   = (state == S_PUSH) && (evt != '0);
    assign fifo_pop    = csr_read && (csr_address == CSR_EVENT) && !fifo_empty;
    assign ovf_set     = fifo_push && fifo_full && !fifo_pop;

`ifdef EVT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt;
    logic [TS_WIDTH-1:0] ts_cap;
    logic [TS_WIDTH-1:0] head_ts;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt <= '0;
            ts_cap <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (state == S_CAP)
                ts_cap <= ts_cnt;
        end
    end

    assign fifo_din              = {ts_cap, evt};
    assign {head_ts, head_evt}   = fifo_head;
`else
    // TS_WIDTH has no effect without the timestamp option.
    logic [TS_WIDTH-1:0] unused_ts;
    assign unused_ts = '0;
    assign fifo_din  = evt;
    assign head_evt  = fifo_head;
`endif

    pio_push_evt_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .din       (fifo_din),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .empty_nxt (fifo_empty_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: state_nxt = S_IDLE;
            S_IDLE: begin
                if (mask_pend)
                    state_nxt = S_MASK;
                else if (pio_irq)
                    state_nxt = S_RD;
            end
            S_RD:   state_nxt = S_CAP;
            S_CAP:  state_nxt = S_PUSH;
            S_PUSH: state_nxt = S_IDLE;
            S_MASK: state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    // Bus strobes are registered from the next state so each access is on the bus
    // while the FSM sits in the matching state; the post-reset write trails S_INIT.
    always_comb begin
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = ADDR_DATA;
        wd_d   = '0;
        if (state == S_INIT || state_nxt == S_MASK) begin
            cs_d   = 1'b1;
            wn_d   = 1'b0;
            addr_d = ADDR_MASK;
            wd_d   = 32'(mask_d);
        end else if (state_nxt == S_RD) begin
            cs_d   = 1'b1;
            addr_d = ADDR_EDGE;
        end else if (state_nxt == S_CAP) begin
            cs_d   = 1'b1;
            wn_d   = 1'b0;
            addr_d = ADDR_EDGE;
        end
    end

    always_comb begin
        rd_d = '0;
        if (csr_read) begin
            case (csr_address)
                CSR_EVENT: begin
                    if (!fifo_empty) begin
                        rd_d[EVT_VALID]  = 1'b1;
                        rd_d[NBTN-1:0]   = head_evt;
                    end
                end
                CSR_STATUS: begin
                    rd_d[7:0]        = 8'(fifo_level);
                    rd_d[STAT_OVF]   = overflow;
                    rd_d[STAT_FULL]  = fifo_full;
                    rd_d[STAT_EMPTY] = fifo_empty;
                end
                CSR_MASK: rd_d[NBTN-1:0] = mask_reg;
                CSR_TS: begin
`ifdef EVT_TIMESTAMP_EN
                    if (!fifo_empty)
                        rd_d[TS_WIDTH-1:0] = head_ts;
`endif
                end
                default: rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_address    <= '0;
            pio_writedata  <= '0;
            csr_readdata   <= '0;
            irq            <= 1'b0;
            evt            <= '0;
            mask_reg       <= INIT_MASK;
            mask_pend      <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            pio_chipselect <= cs_d;
            pio_write_n    <= wn_d;
            pio_address    <= addr_d;
            pio_writedata  <= wd_d;
            csr_readdata   <= rd_d;
            irq            <= !fifo_empty_nxt;
            if (state == S_CAP)
                evt <= pio_readdata[NBTN-1:0];
            mask_reg <= mask_d;
            if (csr_mask_wr)
                mask_pend <= 1'b1;
            else if (state == S_MASK)
                mask_pend <= 1'b0;
            overflow <= ovf_set || (overflow && !csr_ovf_clr);
        end
    end
endmodule

// File: tb/tb_pio_push_event_sequencer.sv
// Directed bench for pio_push_event_sequencer with a behavioural 4-button PIO model.
`timescale 1ns/1ps
module tb_pio_push_event_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = '0;
    logic        pio_irq;
    logic [1:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic        irq;

    logic [3:0]  edge_cap = '0;
    logic [3:0]  pio_mask = '0;
    logic [3:0]  inj = '0;
    logic        irq_force = 1'b0;
    logic [7:0]  bus_log [$];
    int          n_cmp;
    int          n_err;

    always #5 clk = ~clk;

    pio_push_event_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .csr_address    (csr_address),
        .csr_read       (csr_read),
        .csr_write      (csr_write),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .irq            (irq)
    );

    // PIO model: log entry = {write_n, address, 0, mask write data}
    assign pio_irq = (|(edge_cap & pio_mask)) | irq_force;

    always @(posedge clk) begin
        if (pio_chipselect) begin
            bus_log.push_back({pio_write_n, pio_address, 1'b0,
                               (!pio_write_n && pio_address == 2'd2) ? pio_writedata[3:0] : 4'h0});
            if (!pio_write_n && pio_address == 2'd2)
                pio_mask <= pio_writedata[3:0];
        end
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
            edge_cap <= inj;
        else
            edge_cap <= edge_cap | inj;
        pio_readdata <= (pio_chipselect && pio_write_n && pio_address == 2'd3) ? {28'h0, edge_cap} : 32'h0;
    end

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a;
        csr_read    = 1'b1;
        @(negedge clk);
        csr_read    = 1'b0;
        d = csr_readdata;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] v);
        csr_address   = a;
        csr_writedata = v;
        csr_write     = 1'b1;
        @(negedge clk);
        csr_write     = 1'b0;
    endtask

    task automatic inject(input logic [3:0] v);
        inj = v;
        @(negedge clk);
        inj = 4'h0;
    endtask

    task automatic wait_rd(output int cyc);
        cyc = 0;
        while (!(pio_chipselect && pio_write_n && pio_address == 2'd3) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0; csr_read = 1'b0; csr_write = 1'b0; csr_address = '0; csr_writedata = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (pio_chipselect !== 1'b0) begin n_err++; $display("FAIL rst_cs got %b want 0", pio_chipselect); end
        n_cmp++; if (pio_write_n !== 1'b1) begin n_err++; $display("FAIL rst_write_n got %b want 1", pio_write_n); end
        n_cmp++; if (pio_address !== 2'd0) begin n_err++; $display("FAIL rst_addr got %0d want 0", pio_address); end
        n_cmp++; if (pio_writedata !== 32'h0) begin n_err++; $display("FAIL rst_wd got %h want 0", pio_writedata); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b want 0", irq); end
        n_cmp++; if (csr_readdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", csr_readdata); end
        bus_log.delete();
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b1, 1'b0, 2'd2, 32'hF})
            begin n_err++; $display("FAIL init_write got cs=%b wn=%b a=%0d d=%h want cs=1 wn=0 a=2 d=f",
                                    pio_chipselect, pio_write_n, pio_address, pio_writedata); end
        @(negedge clk);
        n_cmp++; if (pio_chipselect !== 1'b0) begin n_err++; $display("FAIL init_idle_cs got %b want 0", pio_chipselect); end
        n_cmp++; if (pio_mask !== 4'hF) begin n_err++; $display("FAIL init_pio_mask got %h want f", pio_mask); end
        n_cmp++; if (bus_log.size() !== 1) begin n_err++; $display("FAIL init_access_count got %0d want 1", bus_log.size()); end
        csr_rd(2'd1, d);
        n_cmp++; if (d !== 32'h400) begin n_err++; $display("FAIL init_status got %h want 00000400", d); end
    endtask

    task automatic test_single_event();
        logic [31:0] d;
        int cyc;
        bus_log.delete();
        inject(4'h5);
        cyc = 0;
        while (!irq && cyc < 20) begin @(negedge clk); cyc++; end
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL single_latency got %0d want 4", cyc); end
        repeat (3) @(negedge clk);
        n_cmp++; if (bus_log.size() !== 2) begin n_err++; $display("FAIL single_access_count got %0d want 2", bus_log.size()); end
        else begin
            n_cmp++; if (bus_log[0] !== 8'hE0) begin n_err++; $display("FAIL single_rd got %h want e0", bus_log[0]); end
            n_cmp++; if (bus_log[1] !== 8'h60) begin n_err++; $display("FAIL single_clr got %h want 60", bus_log[1]); end
        end
        n_cmp++; if (edge_cap !== 4'h0) begin n_err++; $display("FAIL single_edge_cleared got %h want 0", edge_cap); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL single_irq got %b want 1", irq); end
        csr_rd(2'd1, d);
        n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL single_status1 got %h want 00000001", d); end
        csr_rd(2'd0, d);
        n_cmp++; if (d !== 32'h8000_0005) begin n_err++; $display("FAIL single_pop got %h want 80000005", d); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL single_irq_after_pop got %b want 0", irq); end
        csr_rd(2'd1, d);
        n_cmp++; if (d !== 32'h400) begin n_err++; $display("FAIL single_status0 got %h want 00000400", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 1; i <= 9; i++) begin
            inject(4'(i));
            repeat (7) @(negedge clk);
        end
        csr_rd(2'd1, d);
        n_cmp++; if (d !== 32'h308) begin n_err++; $display("FAIL ovf_status got %h want 00000308", d); end
        for (int i = 1; i <= 8; i++) begin
            csr_rd(2'd0, d);
            n_cmp++; if (d !== (32'h8000_0000 | 32'(i)))
                begin n_err++; $display("FAIL ovf_pop%0d got %h want %h", i, d, 32'h8000_0000 | 32'(i)); end
        end
        csr_rd(2'd1, d);
        n_cmp++; if (d !== 32'h500) begin n_err++; $display("FAIL ovf_sticky got %h want 00000500", d); end
        csr_wr(2'd1, 32'h0);
        csr_rd(2'd1, d);
        n_cmp++; if (d !== 32'h500) begin n_err++; $display("FAIL ovf_noclear got %h want 00000500", d); end
        csr_wr(2'd1, 32'h100);
        csr_rd(2'd1, d);
        n_cmp++; if (d !== 32'h400) begin n_err++; $display("FAIL ovf_clear got %h want 00000400", d); end
    endtask

    task automatic test_mask_priority();
        logic [31:0] d;
        int cyc;
        bus_log.delete();
        inject(4'h2);
        wait_rd(cyc);
        n_cmp++; if (cyc >= 20) begin n_err++; $display("FAIL mask_wait_rd got timeout want read"); end
        csr_wr(2'd2, 32'h3);
        @(negedge clk);
        inject(4'h1);
        repeat (12) @(negedge clk);
        n_cmp++; if (bus_log.size() !== 5) begin n_err++; $display("FAIL mask_access_count got %0d want 5", bus_log.size()); end
        else begin
            n_cmp++; if ({bus_log[0], bus_log[1], bus_log[2], bus_log[3], bus_log[4]} !== 40'hE0_60_43_E0_60)
                begin n_err++; $display("FAIL mask_order got %h %h %h %h %h want e0 60 43 e0 60",
                                        bus_log[0], bus_log[1], bus_log[2], bus_log[3], bus_log[4]); end
        end
        n_cmp++; if (pio_mask !== 4'h3) begin n_err++; $display("FAIL mask_pio got %h want 3", pio_mask); end
        csr_rd(2'd2, d);
        n_cmp++; if (d !== 32'h3) begin n_err++; $display("FAIL mask_csr got %h want 00000003", d); end
        csr_rd(2'd0, d);
        n_cmp++; if (d !== 32'h8000_0002) begin n_err++; $display("FAIL mask_pop1 got %h want 80000002", d); end
        csr_rd(2'd0, d);
        n_cmp++; if (d !== 32'h8000_0001) begin n_err++; $display("FAIL mask_pop2 got %h want 80000001", d); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        bus_log.delete();
        irq_force = 1'b1;
        @(negedge clk);
        irq_force = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++; if (bus_log.size() !== 2) begin n_err++; $display("FAIL glitch_access_count got %0d want 2", bus_log.size()); end
        else begin
            n_cmp++; if ({bus_log[0], bus_log[1]} !== 16'hE0_60)
                begin n_err++; $display("FAIL glitch_order got %h %h want e0 60", bus_log[0], bus_log[1]); end
        end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL glitch_irq got %b want 0", irq); end
        csr_rd(2'd1, d);
        n_cmp++; if (d !== 32'h400) begin n_err++; $display("FAIL glitch_status got %h want 00000400", d); end
        csr_rd(2'd0, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL empty_pop got %h want 00000000", d); end
        csr_rd(2'd1, d);
        n_cmp++; if (d !== 32'h400) begin n_err++; $display("FAIL empty_pop_status got %h want 00000400", d); end
        csr_rd(2'd3, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL csr3_empty got %h want 00000000", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int cyc;
        bus_log.delete();
        inject(4'h6);
        wait_rd(cyc);
        n_cmp++; if (cyc >= 20) begin n_err++; $display("FAIL rstmid_wait_rd got timeout want read"); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (pio_chipselect !== 1'b0) begin n_err++; $display("FAIL rstmid_abort got %b want 0", pio_chipselect); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++; if (bus_log.size() !== 3) begin n_err++; $display("FAIL rstmid_access_count got %0d want 3", bus_log.size()); end
        else begin
            n_cmp++; if ({bus_log[0], bus_log[1], bus_log[2]} !== 24'h4F_E0_60)
                begin n_err++; $display("FAIL rstmid_order got %h %h %h want 4f e0 60", bus_log[0], bus_log[1], bus_log[2]); end
        end
        csr_rd(2'd2, d);
        n_cmp++; if (d !== 32'hF) begin n_err++; $display("FAIL rstmid_mask got %h want 0000000f", d); end
        csr_rd(2'd0, d);
        n_cmp++; if (d !== 32'h8000_0006) begin n_err++; $display("FAIL rstmid_pop got %h want 80000006", d); end
    endtask

`ifdef EVT_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [31:0] d;
        logic [31:0] ts_a;
        logic [31:0] ts_b;
        logic [15:0] diff;
        inject(4'h1);
        repeat (99) @(negedge clk);
        inject(4'h2);
        repeat (12) @(negedge clk);
        csr_rd(2'd3, ts_a);
        csr_rd(2'd1, d);
        n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL ts_level got %h want 00000002", d); end
        csr_rd(2'd0, d);
        n_cmp++; if (d !== 32'h8000_0001) begin n_err++; $display("FAIL ts_pop1 got %h want 80000001", d); end
        csr_rd(2'd3, ts_b);
        diff = ts_b[15:0] - ts_a[15:0];
        n_cmp++; if (diff !== 16'd100) begin n_err++; $display("FAIL ts_delta got %0d want 100", diff); end
        csr_rd(2'd0, d);
        n_cmp++; if (d !== 32'h8000_0002) begin n_err++; $display("FAIL ts_pop2 got %h want 80000002", d); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_event();
        test_overflow();
        test_mask_priority();
        test_glitch();
        test_reset_mid();
`ifdef EVT_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
